data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning the number of cycles from request acceptance to ack; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of storage.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-low.
REQ-005 req_i  input  1  access request from the CPU MEM stage (MemRead or MemWrite).
REQ-006 we_i  input  1  1 = word write, 0 = word read; valid with req_i.
REQ-007 addr_i  input  32  byte address; valid with req_i.
REQ-008 wdata_i  input  32  write data; valid with req_i.
REQ-009 ready_o  output  1  block can accept a request this cycle.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 rdata_o  output  32  read data; valid when ack_o=1 for a read.
REQ-012 err_o  output  1  access error flag; valid when ack_o=1.
REQ-013 stall_o  output  1  pipeline stall request to the CPU hazard logic.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 ready_o SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur on an edge where the state is IDLE and req_i=1.
- On acceptance, we_i, addr_i and wdata_i SHALL be latched.
- The next state SHALL be BUSY with the counter loaded to LATENCY-1.
- When LATENCY=1, the next state SHALL be DONE directly.
REQ-017 In BUSY, the counter SHALL decrement each cycle; on the edge where the counter equals 1, the next state SHALL be DONE.
REQ-018 ack_o SHALL be 1 exactly in the cycle LATENCY cycles after the accepting edge, and only in DONE.
REQ-019 DONE SHALL last one cycle and always return to IDLE.
- req_i SHALL be ignored in DONE and BUSY.
- A request still held in the following IDLE cycle SHALL be accepted as a new access.
REQ-020 A write SHALL commit on the edge leaving DONE; a read in DONE SHALL return the latched-address word, including a write committed by any earlier access.
REQ-021 stall_o SHALL equal ~ack_o & (req_i | state==BUSY), combinational, so the MEM stage advances in the ack cycle.
REQ-022 An error SHALL be flagged when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
- Error accesses SHALL keep the full LATENCY timing.
- err_o SHALL be 1 with ack_o.
- Memory SHALL NOT be modified, and rdata_o SHALL be 0.
REQ-023 rdata_o and err_o SHALL update only in the DONE cycle; rdata_o SHALL hold its last value otherwise; a write ack SHALL leave rdata_o unchanged.
REQ-024 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; no byte or halfword access.

Reset
REQ-025 On rst_i=0, the state SHALL go to IDLE immediately (asynchronously) and the counter SHALL clear to 0.
- ready_o SHALL be 1; ack_o, err_o and stall_o (given req_i=0) SHALL be 0; rdata_o SHALL be 0.
REQ-026 Reset mid-access SHALL discard the pending access: no write commit and no ack.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-028 Shared package dmem_pkg SHALL hold the state enum (IDLE/BUSY/DONE), LATENCY_DEFAULT=4, DEPTH_WORDS_DEFAULT=256 and WORD_W=32.
REQ-029 The latency countdown SHALL be one sub-module, lat_counter: load, decrement, and a terminal flag, 4 bits wide.
REQ-030 The storage SHALL be an inferred register array with a synchronous write port, inside data_mem_responder.

Verification
REQ-031 Reset then write, LATENCY=4: write 0x0000_0010 <- 0xDEAD_BEEF.
- ack_o SHALL be high on cycle 4 only; stall_o SHALL be high on cycles 0-3; err_o=0.
- A subsequent read of 0x10 SHALL return 0xDEAD_BEEF at its ack.
REQ-032 LATENCY=1: read 0x0 after reset.
- ack_o SHALL be high one cycle after acceptance with stall_o low in that cycle.
- No BUSY state SHALL occur.
REQ-033 Misaligned read 0x0000_0006, and write 0x0000_0400 with DEPTH_WORDS=256:
- Both SHALL give err_o=1 with ack_o at LATENCY, and rdata_o=0.
- Memory SHALL be unchanged, checked by reading 0x0.
REQ-034 req_i held high continuously over two reads (0x4, 0x8):
- Acks SHALL arrive LATENCY+1 cycles apart.
- The second access SHALL be accepted in the IDLE cycle after DONE, and requests in BUSY/DONE SHALL be ignored.
REQ-035 Write 0x20 <- 0x1234_5678 with rst_i pulsed low during BUSY:
- No ack SHALL occur, and the state SHALL be IDLE immediately.
- A later read of 0x20 SHALL return the prior contents, not 0x1234_5678.
REQ-036 Write then immediate re-request read of the same address 0x30 <- 0xA5A5_A5A5: the read ack SHALL return 0xA5A5_A5A5.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data memory responder.
package dmem_pkg;
    localparam int LATENCY_DEFAULT     = 4;
    localparam int DEPTH_WORDS_DEFAULT = 256;
    localparam int WORD_W              = 32;
    localparam int CNT_W               = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/data_mem_responder_lat_counter.sv
// lat_counter: loadable 4-bit latency countdown with a terminal (count==1) flag.
module lat_counter
    import dmem_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             term_o
);
    logic [CNT_W-1:0] r_count;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_count <= '0;
        else if (load_i)
            r_count <= load_val_i;
        else if (dec_i && r_count != '0)
            r_count <= r_count - 1'b1;
    end
    assign term_o = r_count == CNT_W'(1);
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory answering CPU MEM-stage requests
// with a one-cycle ack, an error flag for bad addresses, and a stall request.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY     = LATENCY_DEFAULT,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              stall_o
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            r_state;
    logic              r_ready, r_ack, r_err, r_we;
    logic [31:0]       r_addr, r_wdata, r_rdata;
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    logic              w_accept, w_term, w_enter_done, w_acc_we, w_acc_err, w_commit;
    logic [31:0]       w_acc_addr;
    logic [IDX_W-1:0]  w_acc_idx, w_wr_idx;
    state_t            w_next;

    lat_counter u_lat (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_accept),
        .load_val_i (CNT_W'(LATENCY - 1)),
        .dec_i      (r_state == BUSY),
        .term_o     (w_term)
    );

    // With LATENCY=1 DONE is entered straight from IDLE, before the request is latched.
    assign w_accept     = r_state == IDLE && req_i;
    assign w_enter_done = (w_accept && LATENCY == 1) || (r_state == BUSY && w_term);
    assign w_acc_we     = r_state == IDLE ? we_i : r_we;
    assign w_acc_addr   = r_state == IDLE ? addr_i : r_addr;
    assign w_acc_err    = w_acc_addr[1:0] != 2'b00 || {2'b00, w_acc_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign w_acc_idx    = w_acc_addr[IDX_W+1:2];
    assign w_wr_idx     = r_addr[IDX_W+1:2];
    assign w_commit     = r_state == DONE && r_we && !r_err;
    assign w_next       = w_enter_done ? DONE :
                          w_accept ? BUSY :
                          r_state == DONE ? IDLE : r_state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= we_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (w_enter_done) begin
                r_err <= w_acc_err;
                if (w_acc_err)
                    r_rdata <= '0;
                else if (!w_acc_we)
                    r_rdata <= r_mem[w_acc_idx];
            end
            r_state <= w_next;
            r_ready <= w_next == IDLE;
            r_ack   <= w_next == DONE;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_commit)
            r_mem[w_wr_idx] <= r_wdata;
    end

    assign ready_o = r_ready;
    assign ack_o   = r_ack;
    assign rdata_o = r_rdata;
    assign err_o   = r_err;
    assign stall_o = ~r_ack & (req_i | r_state == BUSY);
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of timing, data, errors and reset for two latencies.
module tb_data_mem_responder;
    logic        clk, rst_n, req, we;
    logic [31:0] addr, wdata;
    logic        ready, ack, err, stall;
    logic [31:0] rdata;
    logic        ready1, ack1, err1, stall1;
    logic [31:0] rdata1;
    int          errors, checks;

    data_mem_responder #(.LATENCY(4), .DEPTH_WORDS(256)) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready), .ack_o(ack), .rdata_o(rdata), .err_o(err), .stall_o(stall)
    );

    data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .stall_o(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access held for a single request cycle, observed over a fixed 12-cycle window.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int ack_cyc, output int n_ack, output logic [11:0] stall_mask,
                          output logic [31:0] rd, output logic er,
                          output int a1_cyc, output logic [31:0] rd1);
        req = 1'b1; we = w; addr = a; wdata = d;
        ack_cyc = -1; n_ack = 0; stall_mask = '0; rd = '0; er = 1'b0; a1_cyc = -1; rd1 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            stall_mask[c] = stall;
            if (ack) begin
                n_ack++;
                if (ack_cyc < 0) begin ack_cyc = c; rd = rdata; er = err; end
            end
            if (ack1 && a1_cyc < 0) begin a1_cyc = c; rd1 = rdata1; end
            @(posedge clk); #1;
            req = 1'b0;
        end
    endtask

    // Two accesses with req held high throughout; the second is presented right after the first ack.
    task automatic two_access(input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                              input logic w2, input logic [31:0] a2,
                              output int c1, output int c2, output int n,
                              output logic [31:0] r1, output logic [31:0] r2,
                              output logic [15:0] rdy, output logic s1);
        req = 1'b1; we = w1; addr = a1; wdata = d1;
        c1 = -1; c2 = -1; n = 0; r1 = '0; r2 = '0; rdy = '0; s1 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rdy[c] = ready;
            if (ack) begin
                n++;
                if (c1 < 0) begin c1 = c; r1 = rdata; s1 = stall; end
                else if (c2 < 0) begin c2 = c; r2 = rdata; end
            end
            @(posedge clk); #1;
            if (c1 == c) begin we = w2; addr = a2; end
            if (c2 == c) req = 1'b0;
        end
        req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready_l1: got %b want 1", ready1); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency1;
        req = 1'b1; we = 1'b0; addr = 32'h0;
        @(negedge clk);
        checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL l1_stall_c0: got %b want 1", stall1); end
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL l1_ack_c0: got %b want 0", ack1); end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL l1_ack_c1: got %b want 1", ack1); end
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL l1_stall_c1: got %b want 0", stall1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL l1_err_c1: got %b want 0", err1); end
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL l1_ready_c1: got %b want 0", ready1); end
        @(negedge clk);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL l1_ack_c2: got %b want 0", ack1); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL l1_ready_c2: got %b want 1", ready1); end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_write_read;
        int ac, na, a1c; logic [11:0] sm; logic [31:0] rd, rd1; logic er;
        access(1'b1, 32'h0, 32'hCAFE_0000, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (ac !== 4) begin errors++; $display("FAIL wr0_ack_cycle: got %0d want 4", ac); end
        checks++; if (a1c !== 1) begin errors++; $display("FAIL wr0_ack_cycle_l1: got %0d want 1", a1c); end
        access(1'b1, 32'h10, 32'hDEAD_BEEF, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (ac !== 4) begin errors++; $display("FAIL wr10_ack_cycle: got %0d want 4", ac); end
        checks++; if (na !== 1) begin errors++; $display("FAIL wr10_ack_count: got %0d want 1", na); end
        checks++; if (sm !== 12'h00F) begin errors++; $display("FAIL wr10_stall_mask: got %h want 00f", sm); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr10_err: got %b want 0", er); end
        access(1'b0, 32'h10, 32'h0, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd10_data: got %h want deadbeef", rd); end
        checks++; if (ac !== 4) begin errors++; $display("FAIL rd10_ack_cycle: got %0d want 4", ac); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd10_err: got %b want 0", er); end
        checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd10_data_l1: got %h want deadbeef", rd1); end
        access(1'b1, 32'h14, 32'h0000_0055, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr14_rdata_hold: got %h want deadbeef", rd); end
    endtask

    task automatic test_errors;
        int ac, na, a1c; logic [11:0] sm; logic [31:0] rd, rd1; logic er;
        access(1'b0, 32'h6, 32'h0, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (ac !== 4) begin errors++; $display("FAIL mis_ack_cycle: got %0d want 4", ac); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h want 0", rd); end
        access(1'b0, 32'h10, 32'h0, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd10_again: got %h want deadbeef", rd); end
        access(1'b1, 32'h400, 32'h9999_9999, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (ac !== 4) begin errors++; $display("FAIL oob_ack_cycle: got %0d want 4", ac); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oob_err: got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oob_rdata: got %h want 0", rd); end
        access(1'b0, 32'h0, 32'h0, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (rd !== 32'hCAFE_0000) begin errors++; $display("FAIL mem0_unchanged: got %h want cafe0000", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL mem0_err: got %b want 0", er); end
    endtask

    task automatic test_back_to_back;
        int ac, na, a1c, c1, c2, n; logic [11:0] sm; logic [31:0] rd, rd1, r1, r2; logic er, s1;
        logic [15:0] rdy;
        access(1'b1, 32'h4, 32'h4444_4444, ac, na, sm, rd, er, a1c, rd1);
        access(1'b1, 32'h8, 32'h8888_8888, ac, na, sm, rd, er, a1c, rd1);
        two_access(1'b0, 32'h4, 32'h0, 1'b0, 32'h8, c1, c2, n, r1, r2, rdy, s1);
        checks++; if (c1 !== 4) begin errors++; $display("FAIL b2b_ack1_cycle: got %0d want 4", c1); end
        checks++; if (c2 !== 9) begin errors++; $display("FAIL b2b_ack2_cycle: got %0d want 9", c2); end
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d want 2", n); end
        checks++; if (r1 !== 32'h4444_4444) begin errors++; $display("FAIL b2b_rdata1: got %h want 44444444", r1); end
        checks++; if (r2 !== 32'h8888_8888) begin errors++; $display("FAIL b2b_rdata2: got %h want 88888888", r2); end
        checks++; if (s1 !== 1'b0) begin errors++; $display("FAIL b2b_stall_at_ack: got %b want 0", s1); end
        checks++; if (rdy[9:0] !== 10'b00_0010_0001) begin errors++; $display("FAIL b2b_ready_pattern: got %b want 0000100001", rdy[9:0]); end
    endtask

    task automatic test_reset_mid;
        int ac, na, a1c, n; logic [11:0] sm; logic [31:0] rd, rd1; logic er;
        access(1'b1, 32'h20, 32'h1111_2222, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (ac !== 4) begin errors++; $display("FAIL pre20_ack_cycle: got %0d want 4", ac); end
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_busy_ready: got %b want 0", ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready: got %b want 1", ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_async_stall: got %b want 0", stall); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_async_rdata: got %h want 0", rdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d acks want 0", n); end
        @(posedge clk); #1;
        access(1'b0, 32'h20, 32'h0, ac, na, sm, rd, er, a1c, rd1);
        checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL mid_no_commit: got %h want 11112222", rd); end
    endtask

    task automatic test_reread;
        int c1, c2, n; logic [31:0] r1, r2; logic [15:0] rdy; logic s1;
        two_access(1'b1, 32'h30, 32'hA5A5_A5A5, 1'b0, 32'h30, c1, c2, n, r1, r2, rdy, s1);
        checks++; if (c2 !== 9) begin errors++; $display("FAIL reread_ack_cycle: got %0d want 9", c2); end
        checks++; if (r2 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL reread_data: got %h want a5a5a5a5", r2); end
        checks++; if (r1 !== 32'h1111_2222) begin errors++; $display("FAIL reread_wr_hold: got %h want 11112222", r1); end
    endtask

    initial begin
        errors = 0; checks = 0;
        test_reset;
        test_latency1;
        test_write_read;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        test_reread;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
